// File: rtl/ama_riscv_fetch_if.sv
// IMEM read bus between the fetch stage (master) and the instruction memory (slave).
// The read data is valid one cycle after imem_en is sampled high.
interface ama_riscv_fetch_if #(
    parameter int IMEM_AW = 14
) ();
    logic               imem_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;

    modport master (output imem_en, output imem_addr, input imem_rdata);
    modport slave  (input imem_en, input imem_addr, output imem_rdata);
endinterface

// File: rtl/ama_riscv_fetch.sv
// IF stage: owns the PC, issues IMEM reads and hands inst_id/pc_id to ID one cycle later.
// Inserts NOP bubbles on stall, squash and after reset; tracks deliveries and misaligned redirects.
module ama_riscv_fetch #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0200,
    parameter int          IMEM_AW   = 14,
    parameter int          CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         pc_sel,
    input  logic               pc_we,
    input  logic               stall_if,
    input  logic               clear_if,
    input  logic [31:0]        alu_out,
    ama_riscv_fetch_if.master  imem,
    output logic [31:0]        inst_id,
    output logic               inst_id_valid,
    output logic [31:0]        pc_id,
    output logic [31:0]        pc_id_inc4,
    output logic               fetch_misaligned,
    output logic [CNT_W-1:0]   fetch_cnt
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [1:0] PC_SEL_INC4       = 2'd0;
    localparam logic [1:0] PC_SEL_ALU        = 2'd1;
    localparam logic [1:0] PC_SEL_START_ADDR = 2'd2;

    logic [31:0]      pc_q;
    logic             req_q;
    logic             kill_q;
    logic [31:0]      pc_id_q;
    logic             misalign_q;
    logic [CNT_W-1:0] cnt_q;

    logic             pc_upd;
    logic [31:0]      pc_next;

    function automatic logic [31:0] next_pc(input logic [1:0]  sel,
                                            input logic [31:0] pc,
                                            input logic [31:0] target);
        case (sel)
            PC_SEL_INC4:       next_pc = pc + 32'd4;
            PC_SEL_ALU:        next_pc = {target[31:2], 2'b00};
            PC_SEL_START_ADDR: next_pc = RESET_VEC;
            default:           next_pc = pc;
        endcase
    endfunction

    // Issue: a stall suppresses both the fetch and the PC update
    assign imem.imem_en   = rst_n && !stall_if;
    assign imem.imem_addr = pc_q[IMEM_AW+1:2];

    assign pc_upd  = pc_we && !stall_if;
    assign pc_next = next_pc(pc_sel, pc_q, alu_out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_VEC;
            req_q      <= 1'b0;
            kill_q     <= 1'b0;
            pc_id_q    <= RESET_VEC;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            req_q  <= imem.imem_en;
            kill_q <= clear_if;
            if (imem.imem_en)
                pc_id_q <= pc_q;
            // A redirect still lands when the same cycle's fetch is squashed
            if (pc_upd)
                pc_q <= pc_next;
            if (pc_upd && (pc_sel == PC_SEL_ALU) && (alu_out[1:0] != 2'b00))
                misalign_q <= 1'b1;
            if (inst_id_valid)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Delivery: response of last cycle's fetch unless it was squashed
    assign inst_id_valid    = req_q && !kill_q;
    assign inst_id          = inst_id_valid ? imem.imem_rdata : NOP;
    assign pc_id            = pc_id_q;
    assign pc_id_inc4       = pc_id_q + 32'd4;
    assign fetch_misaligned = misalign_q;
    assign fetch_cnt        = cnt_q;

endmodule
